// File: rtl/mem_scan.sv
// mem_scan: built-in RAM self test. Writes a base pattern XOR address to the
// internal RAM, reads it back and compares, then repeats with the inverted
// pattern. Reports the first mismatch and drives a 32-bit display value.
// Optional build macro: MEM_SCAN_FAULT_INJ_EN adds inj_en/inj_addr, which flip
// bit 0 of any word written to inj_addr so that the compare path can be exercised.
module mem_scan #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            pat_sel,
`ifdef MEM_SCAN_FAULT_INJ_EN
    input  logic                  inj_en,
    input  logic [ADDR_WIDTH-1:0] inj_addr,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [31:0]           disp_data
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // 32-bit base pattern for each select value
    function automatic logic [31:0] f_base32(input logic [1:0] sel);
        case (sel)
            2'd0:    return 32'h1234_5678;
            2'd1:    return 32'h8765_4321;
            2'd2:    return 32'hFEDC_BA98;
            2'd3:    return 32'h89AB_CDEF;
            default: return 32'h1234_5678;
        endcase
    endfunction

    // Base pattern replicated or truncated to the RAM word, LSB aligned
    function automatic logic [DATA_WIDTH-1:0] f_base(input logic [1:0] sel);
        logic [63:0] rep;
        rep = {f_base32(sel), f_base32(sel)};
        return rep[DATA_WIDTH-1:0];
    endfunction

    // Word expected at an address: base ^ address, inverted in the second pass
    function automatic logic [DATA_WIDTH-1:0] f_expected(
        input logic [1:0]            sel,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  pass
    );
        logic [63:0]           a_ext;
        logic [DATA_WIDTH-1:0] val;
        a_ext                 = 64'd0;
        a_ext[ADDR_WIDTH-1:0] = addr;
        val                   = f_base(sel) ^ a_ext[DATA_WIDTH-1:0];
        return pass ? ~val : val;
    endfunction

    // RAM word zero-extended or truncated to the 32-bit display width
    function automatic logic [31:0] f_to32(input logic [DATA_WIDTH-1:0] d);
        logic [63:0] t;
        t                 = 64'd0;
        t[DATA_WIDTH-1:0] = d;
        return t[31:0];
    endfunction

    state_t                  r_state;
    logic                    r_pass;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_tail;
    logic                    r_rd_vld;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [1:0]              r_pat;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_fail;
    logic [ADDR_WIDTH-1:0]   r_fail_addr;
    logic [DATA_WIDTH-1:0]   r_fail_data;
    logic [31:0]             r_disp;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_q;

    logic                    w_inj;
    logic                    w_we;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [DATA_WIDTH-1:0]   w_exp;
    logic                    w_mismatch;

`ifdef MEM_SCAN_FAULT_INJ_EN
    assign w_inj = inj_en && (r_addr == inj_addr);
`else
    assign w_inj = 1'b0;
`endif

    assign w_we       = (r_state == S_WRITE);
    assign w_wr_data  = f_expected(r_pat, r_addr, r_pass) ^ {{(DATA_WIDTH-1){1'b0}}, w_inj};
    assign w_exp      = f_expected(r_pat, r_rd_addr, r_pass);
    assign w_mismatch = (r_state == S_READ) && r_rd_vld && (r_q != w_exp);

    // RAM storage: synchronous write, contents are never reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_addr] <= w_wr_data;
        end
    end

    // RAM read port: registered data, one cycle after the address is presented
    always_ff @(posedge clk) begin
        r_q <= r_mem[r_addr];
    end

    // Scan sequencer: phase/pass/address control and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pass      <= 1'b0;
            r_addr      <= {ADDR_WIDTH{1'b0}};
            r_tail      <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_addr   <= {ADDR_WIDTH{1'b0}};
            r_pat       <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= {ADDR_WIDTH{1'b0}};
            r_fail_data <= {DATA_WIDTH{1'b0}};
            r_disp      <= 32'h1234_5678;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state  <= S_WRITE;
                        r_pass   <= 1'b0;
                        r_addr   <= {ADDR_WIDTH{1'b0}};
                        r_tail   <= 1'b0;
                        r_rd_vld <= 1'b0;
                        r_pat    <= pat_sel;
                        r_busy   <= 1'b1;
                        r_fail   <= 1'b0;
                        r_disp   <= f_base32(pat_sel);
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (r_addr == ADDR_LAST) begin
                        r_state  <= S_READ;
                        r_addr   <= {ADDR_WIDTH{1'b0}};
                        r_tail   <= 1'b0;
                        r_rd_vld <= 1'b0;
                    end else begin
                        r_addr <= r_addr + ADDR_ONE;
                    end
                end
                S_READ: begin
                    if (w_mismatch) begin
                        // Abort on the first bad word; keep an earlier capture if one exists
                        r_fail   <= 1'b1;
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_rd_vld <= 1'b0;
                        r_tail   <= 1'b0;
                        r_addr   <= {ADDR_WIDTH{1'b0}};
                        if (!r_fail) begin
                            r_fail_addr <= r_rd_addr;
                            r_fail_data <= r_q;
                            r_disp      <= f_to32(r_q);
                        end
                    end else if (r_tail) begin
                        // Final compare-only cycle of the read phase
                        r_tail   <= 1'b0;
                        r_rd_vld <= 1'b0;
                        if (!r_pass) begin
                            r_state <= S_WRITE;
                            r_pass  <= 1'b1;
                            r_addr  <= {ADDR_WIDTH{1'b0}};
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_rd_addr <= r_addr;
                        r_rd_vld  <= 1'b1;
                        if (r_addr == ADDR_LAST) begin
                            r_tail <= 1'b1;
                            r_addr <= {ADDR_WIDTH{1'b0}};
                        end else begin
                            r_addr <= r_addr + ADDR_ONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
    assign disp_data = r_disp;

endmodule

// File: tb/tb_mem_scan.sv
// tb_mem_scan: directed scenarios for mem_scan with a done-driven scoreboard.
// Build with MEM_SCAN_FAULT_INJ_EN defined to include the fault-injection cases.
module tb_mem_scan;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  pat_sel;
    logic        busy;
    logic        done;
    logic        fail;
    logic [5:0]  fail_addr;
    logic [31:0] fail_data;
    logic [31:0] disp_data;
`ifdef MEM_SCAN_FAULT_INJ_EN
    logic        inj_en;
    logic [5:0]  inj_addr;
`endif

    typedef struct {
        logic        fail;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [31:0] disp;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    mem_scan #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pat_sel   (pat_sel),
`ifdef MEM_SCAN_FAULT_INJ_EN
        .inj_en    (inj_en),
        .inj_addr  (inj_addr),
`endif
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .disp_data (disp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic f, input logic [5:0] a, input logic [31:0] d,
                                input logic [31:0] disp, input int lat);
        exp_t e;
        e.fail = f; e.addr = a; e.data = d; e.disp = disp; e.lat = lat;
        return e;
    endfunction

    // Monitor: pop and compare one expectation on every done pulse
    initial begin : monitor
        exp_t e;
        int   lat_cnt;
        logic prev_done;
        lat_cnt   = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                lat_cnt = 0;
            end else if (done) begin
                done_cnt++;
                chk("done_pulse_width", {63'd0, prev_done}, 64'd0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("fail", {63'd0, fail}, {63'd0, e.fail});
                    chk("disp_data", {32'd0, disp_data}, {32'd0, e.disp});
                    chk("latency", 64'(lat_cnt), 64'(e.lat));
                    if (e.fail) begin
                        chk("fail_addr", {58'd0, fail_addr}, {58'd0, e.addr});
                        chk("fail_data", {32'd0, fail_data}, {32'd0, e.data});
                    end
                end
                lat_cnt = 0;
            end else if (busy) begin
                lat_cnt++;
            end
            prev_done = done;
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (done_cnt >= target) break;
        end
        chk("done_timeout", {63'd0, (done_cnt >= target)}, 64'd1);
    endtask

    task automatic run_scan(input logic [1:0] sel, input exp_t e);
        int target;
        sb_q.push_back(e);
        target = done_cnt + 1;
        @(negedge clk);
        start   = 1'b1;
        pat_sel = sel;
        @(negedge clk);
        start   = 1'b0;
        wait_done(target);
    endtask

    initial begin : stimulus
        int   target;
        exp_t e1;
        rst     = 1'b1;
        start   = 1'b0;
        pat_sel = 2'd0;
`ifdef MEM_SCAN_FAULT_INJ_EN
        inj_en   = 1'b0;
        inj_addr = 6'd0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_fail", {63'd0, fail}, 64'd0);
        chk("rst_fail_addr", {58'd0, fail_addr}, 64'd0);
        chk("rst_fail_data", {32'd0, fail_data}, 64'd0);
        chk("rst_disp", {32'd0, disp_data}, 64'h1234_5678);

        // Clean scans with two different patterns
        run_scan(2'd0, mk(1'b0, 6'd0, 32'd0, 32'h1234_5678, 258));
        run_scan(2'd3, mk(1'b0, 6'd0, 32'd0, 32'h89AB_CDEF, 258));

`ifdef MEM_SCAN_FAULT_INJ_EN
        // Injected fault at address 5: compare of addr 5 happens in busy cycle 71
        inj_en   = 1'b1;
        inj_addr = 6'd5;
        run_scan(2'd1, mk(1'b1, 6'd5, 32'h8765_4325, 32'h8765_4325, 71));
        e1 = mk(1'b1, 6'd5, 32'hFEDC_BA9C, 32'hFEDC_BA9C, 71);
`else
        e1 = mk(1'b0, 6'd0, 32'd0, 32'hFEDC_BA98, 258);
`endif

        // Mid-scan start ignored, start held through DONE relaunches at once
        sb_q.push_back(e1);
        target = done_cnt + 1;
        @(negedge clk);
        start   = 1'b1;
        pat_sel = 2'd2;
        @(negedge clk);
        start   = 1'b0;
        repeat (10) @(negedge clk);
        start   = 1'b1;
        pat_sel = 2'd0;
        @(negedge clk);
        start   = 1'b0;
        chk("busy_mid_scan", {63'd0, busy}, 64'd1);
        repeat (30) @(negedge clk);
        sb_q.push_back(mk(1'b0, 6'd0, 32'd0, 32'h89AB_CDEF, 258));
        pat_sel = 2'd3;
        start   = 1'b1;
        wait_done(target);
        @(negedge clk);
`ifdef MEM_SCAN_FAULT_INJ_EN
        inj_en = 1'b0;
`endif
        chk("idle_between_scans", {63'd0, busy}, 64'd0);
        chk("fail_before_accept", {63'd0, fail}, {63'd0, e1.fail});
        @(negedge clk);
        chk("held_start_busy", {63'd0, busy}, 64'd1);
        chk("fail_cleared_on_accept", {63'd0, fail}, 64'd0);
        start = 1'b0;
        wait_done(target + 1);

        // Asynchronous reset while pass-1 READ issues address 30 (busy cycle 224)
        @(negedge clk);
        start   = 1'b1;
        pat_sel = 2'd1;
        @(negedge clk);
        start   = 1'b0;
        repeat (223) @(posedge clk);
        #2;
        chk("busy_before_rst", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_busy", {63'd0, busy}, 64'd0);
        chk("async_done", {63'd0, done}, 64'd0);
        chk("async_fail", {63'd0, fail}, 64'd0);
        chk("async_fail_addr", {58'd0, fail_addr}, 64'd0);
        chk("async_fail_data", {32'd0, fail_data}, 64'd0);
        chk("async_disp", {32'd0, disp_data}, 64'h1234_5678);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_scan(2'd0, mk(1'b0, 6'd0, 32'd0, 32'h1234_5678, 258));

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
